// File: rtl/spi_apb_frontend.sv
// APB3 slave that queues CPU bytes for spi_master and buffers the bytes it returns.
// TX FIFO -> dispatch FSM -> spi_master; spi_master -> RX FIFO -> APB reads.
module spi_apb_frontend #(
  parameter int DEPTH = 8,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          PSEL,
  input  logic          PENABLE,
  input  logic          PWRITE,
  input  logic [AW-1:0] PADDR,
  input  logic [7:0]    PWDATA,
  output logic [7:0]    PRDATA,
  output logic          PREADY,
  output logic          PSLVERR,
  output logic          spi_apb_ready,
  output logic [7:0]    spi_wdata,
  input  logic          spi_rdy_bsybar,
  input  logic          spi_rx_valid,
  input  logic [7:0]    spi_rdata
);

  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_BSY  = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    wdata_q, wdata_d;
  logic          pready_q, pready_d;
  logic          en_q, en_d;
  logic          txovf_q, txovf_d;
  logic          rxovf_q, rxovf_d;
  logic [PW-1:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
  logic [PW-1:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;

  logic [7:0] tx_mem [DEPTH];
  logic [7:0] rx_mem [DEPTH];

  logic xfer, sel_data, sel_stat, sel_ctrl, bad_addr;
  logic tx_empty, tx_full, rx_empty, rx_full;
  logic tx_push, tx_pop, rx_push, rx_pop, flush;
  logic [7:0] status;

  // Transfers are ignored until the first edge after reset, when PREADY rises.
  assign xfer     = PSEL & PENABLE & pready_q;
  assign sel_data = (PADDR == AW'(0));
  assign sel_stat = (PADDR == AW'(4));
  assign sel_ctrl = (PADDR == AW'(8));
  assign bad_addr = ~(sel_data | sel_stat | sel_ctrl);

  // Pointer MSB differs only when the write pointer has lapped the read pointer.
  assign tx_empty = (tx_wr_q == tx_rd_q);
  assign tx_full  = (tx_wr_q[IW] != tx_rd_q[IW]) && (tx_wr_q[IW-1:0] == tx_rd_q[IW-1:0]);
  assign rx_empty = (rx_wr_q == rx_rd_q);
  assign rx_full  = (rx_wr_q[IW] != rx_rd_q[IW]) && (rx_wr_q[IW-1:0] == rx_rd_q[IW-1:0]);

  assign tx_push = xfer & PWRITE & sel_data & ~tx_full;
  assign tx_pop  = (state_q == IDLE) & en_q & ~tx_empty & spi_rdy_bsybar;
  assign rx_push = spi_rx_valid & ~rx_full;
  assign rx_pop  = xfer & ~PWRITE & sel_data & ~rx_empty;
  assign flush   = xfer & PWRITE & sel_ctrl & PWDATA[1];

  assign status = {1'b0, rxovf_q, txovf_q, (state_q != IDLE),
                   rx_full, rx_empty, tx_full, tx_empty};

  assign PREADY        = pready_q;
  assign spi_apb_ready = (state_q == ISSUE);
  assign spi_wdata     = wdata_q;

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_q[IW-1:0]] <= PWDATA;
    if (rx_push) rx_mem[rx_wr_q[IW-1:0]] <= spi_rdata;
  end

  // APB read mux and error response, live only during the access phase.
  always_comb begin
    PRDATA  = 8'h00;
    PSLVERR = 1'b0;
    if (xfer) begin
      if (bad_addr) begin
        PSLVERR = 1'b1;
      end else if (sel_data) begin
        if (PWRITE) begin
          PSLVERR = tx_full;
        end else if (rx_empty) begin
          PSLVERR = 1'b1;
        end else begin
          PRDATA = rx_mem[rx_rd_q[IW-1:0]];
        end
      end else if (!PWRITE) begin
        if (sel_stat) PRDATA = status;
        else          PRDATA = {7'b0, en_q};
      end
    end
  end

  // FIFO pointers; a flush overrides any push or pop in the same cycle.
  always_comb begin
    tx_wr_d = tx_wr_q;
    tx_rd_d = tx_rd_q;
    rx_wr_d = rx_wr_q;
    rx_rd_d = rx_rd_q;
    if (tx_push) tx_wr_d = tx_wr_q + PW'(1);
    if (tx_pop)  tx_rd_d = tx_rd_q + PW'(1);
    if (rx_push) rx_wr_d = rx_wr_q + PW'(1);
    if (rx_pop)  rx_rd_d = rx_rd_q + PW'(1);
    if (flush) begin
      tx_wr_d = '0;
      tx_rd_d = '0;
      rx_wr_d = '0;
      rx_rd_d = '0;
    end
  end

  // Control register and sticky overflow flags; a new overflow beats a clear.
  always_comb begin
    pready_d = 1'b1;
    en_d     = en_q;
    txovf_d  = txovf_q;
    rxovf_d  = rxovf_q;
    if (xfer && PWRITE && sel_ctrl) en_d = PWDATA[0];
    if (xfer && PWRITE && sel_stat) begin
      if (PWDATA[5]) txovf_d = 1'b0;
      if (PWDATA[6]) rxovf_d = 1'b0;
    end
    if (xfer && PWRITE && sel_data && tx_full) txovf_d = 1'b1;
    if (spi_rx_valid && rx_full)               rxovf_d = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    wdata_d = wdata_q;
    unique case (state_q)
      IDLE: begin
        if (tx_pop) begin
          state_d = ISSUE;
          wdata_d = tx_mem[tx_rd_q[IW-1:0]];
        end
      end
      ISSUE:     state_d = WAIT_BSY;
      WAIT_BSY:  if (!spi_rdy_bsybar) state_d = WAIT_DONE;
      WAIT_DONE: if (spi_rdy_bsybar)  state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      wdata_q  <= 8'h00;
      pready_q <= 1'b0;
      en_q     <= 1'b0;
      txovf_q  <= 1'b0;
      rxovf_q  <= 1'b0;
      tx_wr_q  <= '0;
      tx_rd_q  <= '0;
      rx_wr_q  <= '0;
      rx_rd_q  <= '0;
    end else begin
      state_q  <= state_d;
      wdata_q  <= wdata_d;
      pready_q <= pready_d;
      en_q     <= en_d;
      txovf_q  <= txovf_d;
      rxovf_q  <= rxovf_d;
      tx_wr_q  <= tx_wr_d;
      tx_rd_q  <= tx_rd_d;
      rx_wr_q  <= rx_wr_d;
      rx_rd_q  <= rx_rd_d;
    end
  end

endmodule

// File: tb/tb_spi_apb_frontend.sv
// Scoreboard bench for spi_apb_frontend: queue-based model of both FIFOs and flags,
// a behavioural spi_master responder, and an APB monitor that checks every access.
module tb_spi_apb_frontend;

  localparam int DEPTH = 8;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          PSEL, PENABLE, PWRITE;
  logic [AW-1:0] PADDR;
  logic [7:0]    PWDATA;
  logic [7:0]    PRDATA;
  logic          PREADY, PSLVERR;
  logic          spi_apb_ready;
  logic [7:0]    spi_wdata;
  logic          spi_rdy_bsybar, spi_rx_valid;
  logic [7:0]    spi_rdata;

  spi_apb_frontend #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .spi_apb_ready(spi_apb_ready), .spi_wdata(spi_wdata),
    .spi_rdy_bsybar(spi_rdy_bsybar), .spi_rx_valid(spi_rx_valid), .spi_rdata(spi_rdata)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       wr;
    logic [3:0] addr;
    logic [7:0] prdata;
    logic       pslverr;
  } exp_t;

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [7:0] tx_model[$];
  logic [7:0] rx_model[$];
  logic [7:0] inject_q[$];
  exp_t       apb_exp[$];
  bit en_m = 0, txovf_m = 0, rxovf_m = 0, busy_m = 0;

  // spi_master responder state
  bit         spi_active = 0, cap_pending = 0, cap_is_xfer = 0;
  int         spi_cnt = 0, spi_len_fix = 0, strobe_cnt = 0;
  logic [7:0] held_wdata = 8'h00, cap_byte = 8'h00;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] status_m();
    return {1'b0, rxovf_m, txovf_m, busy_m,
            rx_model.size() == DEPTH, rx_model.size() == 0,
            tx_model.size() == DEPTH, tx_model.size() == 0};
  endfunction

  // One APB transfer. Expectation is queued just before the access edge; the model
  // is updated 2 time units after that edge, after the responder has applied captures.
  task automatic apb(input bit wr, input logic [AW-1:0] a, input logic [7:0] d);
    exp_t e;
    bit   err;
    logic [7:0] rd;
    @(negedge clk);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = a; PWDATA = d;
    @(negedge clk);
    PENABLE = 1'b1;
    err = 1'b0;
    rd  = 8'h00;
    case (a)
      4'h0: begin
        if (wr) err = (tx_model.size() >= DEPTH);
        else if (rx_model.size() == 0) err = 1'b1;
        else rd = rx_model[0];
      end
      4'h4: if (!wr) rd = status_m();
      4'h8: if (!wr) rd = {7'b0, en_m};
      default: err = 1'b1;
    endcase
    e.wr = wr; e.addr = a; e.prdata = rd; e.pslverr = err;
    apb_exp.push_back(e);
    @(posedge clk);
    #2;
    case (a)
      4'h0: begin
        if (wr) begin
          if (err) txovf_m = 1'b1;
          else     tx_model.push_back(d);
        end else if (!err) begin
          void'(rx_model.pop_front());
        end
      end
      4'h4: if (wr) begin
        if (d[5]) txovf_m = 1'b0;
        if (d[6]) rxovf_m = 1'b0;
      end
      4'h8: if (wr) begin
        en_m = d[0];
        if (d[1]) begin
          tx_model.delete();
          rx_model.delete();
        end
      end
      default: ;
    endcase
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic wait_quiet();
    int n = 0;
    while (((en_m && tx_model.size() != 0) || busy_m || inject_q.size() != 0 || cap_pending)
           && n < 3000) begin
      @(posedge clk);
      n++;
    end
    chk("quiet_timeout", int'(n >= 3000), 0);
    repeat (2) @(posedge clk);
  endtask

  task automatic wait_strobe();
    int s = strobe_cnt;
    int n = 0;
    while (strobe_cnt == s && n < 200) begin
      @(posedge clk);
      n++;
    end
    chk("strobe_timeout", int'(n >= 200), 0);
  endtask

  task automatic drain();
    int n = 0;
    while (rx_model.size() != 0 && n < 64) begin
      apb(1'b0, 4'h0, 8'h00);
      n++;
    end
  endtask

  // APB monitor: compares every access phase against the scoreboard queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (PSEL && PENABLE) begin
        if (apb_exp.size() == 0) begin
          chk("apb_unexpected_access", 1, 0);
        end else begin
          e = apb_exp.pop_front();
          $display("apb %s addr=0x%0h prdata=0x%02h pslverr=%0b", e.wr ? "W" : "R",
                   e.addr, PRDATA, PSLVERR);
          chk($sformatf("prdata_a%0h_%s", e.addr, e.wr ? "w" : "r"), int'(PRDATA), int'(e.prdata));
          chk($sformatf("pslverr_a%0h_%s", e.addr, e.wr ? "w" : "r"), int'(PSLVERR), int'(e.pslverr));
          chk("pready", int'(PREADY), 1);
        end
      end
    end
  end

  // Behavioural spi_master: answers each strobe with a busy period and an RX byte,
  // and services injected RX bytes while idle. Sole driver of the spi_* inputs.
  initial begin
    logic [7:0] exp_b;
    spi_rdy_bsybar = 1'b1;
    spi_rx_valid   = 1'b0;
    spi_rdata      = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        spi_rdy_bsybar = 1'b1; spi_rx_valid = 1'b0;
        spi_active = 0; cap_pending = 0; busy_m = 0;
        en_m = 0; txovf_m = 0; rxovf_m = 0;
        tx_model.delete(); rx_model.delete(); inject_q.delete();
      end else begin
        if (cap_pending) begin
          spi_rx_valid = 1'b0;
          cap_pending  = 0;
          if (rx_model.size() < DEPTH) rx_model.push_back(cap_byte);
          else rxovf_m = 1'b1;
          if (cap_is_xfer) busy_m = 0;
        end
        if (spi_apb_ready) begin
          strobe_cnt++;
          if (spi_active || !en_m || tx_model.size() == 0) begin
            chk("unexpected_strobe", 1, 0);
          end else begin
            exp_b = tx_model.pop_front();
            $display("spi strobe wdata=0x%02h", spi_wdata);
            chk("strobe_wdata", int'(spi_wdata), int'(exp_b));
          end
          busy_m = 1; spi_active = 1; held_wdata = spi_wdata;
          spi_cnt = (spi_len_fix != 0) ? spi_len_fix : $urandom_range(2, 5);
          spi_rdy_bsybar = 1'b0;
        end else if (spi_active) begin
          chk("wdata_hold", int'(spi_wdata), int'(held_wdata));
          spi_cnt--;
          if (spi_cnt == 0) begin
            spi_active = 0; spi_rdy_bsybar = 1'b1;
            cap_byte = 8'($urandom); spi_rdata = cap_byte; spi_rx_valid = 1'b1;
            cap_pending = 1; cap_is_xfer = 1;
          end
        end else if (inject_q.size() != 0) begin
          cap_byte = inject_q.pop_front(); spi_rdata = cap_byte; spi_rx_valid = 1'b1;
          cap_pending = 1; cap_is_xfer = 0;
        end
      end
    end
  end

  initial begin
    int s0;
    logic [AW-1:0] ba;
    PSEL = 0; PENABLE = 0; PWRITE = 0; PADDR = '0; PWDATA = 8'h00;

    // Reset values
    @(negedge clk);
    chk("rst_pready", int'(PREADY), 0);
    chk("rst_strobe", int'(spi_apb_ready), 0);
    chk("rst_wdata", int'(spi_wdata), 0);
    chk("rst_prdata", int'(PRDATA), 0);
    chk("rst_pslverr", int'(PSLVERR), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("pready_out_of_reset", int'(PREADY), 1);
    apb(1'b0, 4'h4, 8'h00);
    apb(1'b0, 4'h8, 8'h00);

    // Single byte, busy visible while the transfer is in flight
    apb(1'b1, 4'h8, 8'h01);
    spi_len_fix = 6;
    apb(1'b1, 4'h0, 8'hAA);
    wait_strobe();
    apb(1'b0, 4'h4, 8'h00);
    wait_quiet();
    spi_len_fix = 0;
    drain();

    // TX overflow with dispatch disabled, then ordered dispatch
    apb(1'b1, 4'h8, 8'h00);
    for (int i = 1; i <= DEPTH + 1; i++) apb(1'b1, 4'h0, 8'(i));
    apb(1'b0, 4'h4, 8'h00);
    apb(1'b1, 4'h4, 8'h20);
    apb(1'b0, 4'h4, 8'h00);
    apb(1'b1, 4'h8, 8'h01);
    wait_quiet();
    drain();

    // Returned bytes read back in order, then empty-read error
    apb(1'b1, 4'h8, 8'h00);
    inject_q.push_back(8'h5A);
    inject_q.push_back(8'hC3);
    wait_quiet();
    repeat (3) apb(1'b0, 4'h0, 8'h00);

    // RX overflow, W1C of RXOVF, order preserved
    for (int i = 0; i < DEPTH + 1; i++) inject_q.push_back(8'($urandom));
    wait_quiet();
    apb(1'b0, 4'h4, 8'h00);
    apb(1'b1, 4'h4, 8'h40);
    apb(1'b0, 4'h4, 8'h00);
    drain();

    // FLUSH while a byte is in WAIT_DONE with more queued
    for (int i = 0; i < 4; i++) apb(1'b1, 4'h0, 8'h11 + 8'(i));
    spi_len_fix = 10;
    apb(1'b1, 4'h8, 8'h01);
    s0 = strobe_cnt;
    wait_strobe();
    repeat (4) @(posedge clk);
    apb(1'b1, 4'h8, 8'h03);
    wait_quiet();
    chk("flush_strobes", strobe_cnt - s0, 1);
    apb(1'b0, 4'h4, 8'h00);
    apb(1'b0, 4'h8, 8'h00);
    drain();

    // Asynchronous reset during WAIT_BSY
    apb(1'b1, 4'h8, 8'h00);
    apb(1'b1, 4'h0, 8'h77);
    spi_len_fix = 8;
    apb(1'b1, 4'h8, 8'h01);
    wait_strobe();
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_strobe", int'(spi_apb_ready), 0);
    chk("async_rst_wdata", int'(spi_wdata), 0);
    chk("async_rst_pready", int'(PREADY), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    spi_len_fix = 0;
    repeat (2) @(negedge clk);
    apb(1'b0, 4'h4, 8'h00);
    apb(1'b0, 4'h8, 8'h00);
    apb(1'b0, 4'h0, 8'h00);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 30) begin
        if (!en_m || tx_model.size() < DEPTH) apb(1'b1, 4'h0, 8'($urandom));
        else apb(1'b0, 4'h4, 8'h00);
      end else if (r < 50) begin
        apb(1'b0, 4'h0, 8'h00);
      end else if (r < 60) begin
        apb(1'b0, 4'h4, 8'h00);
      end else if (r < 70) begin
        apb(1'b1, 4'h8, {6'b0, ($urandom_range(0, 9) == 0), ($urandom_range(0, 3) != 0)});
      end else if (r < 75) begin
        apb(1'b1, 4'h4, 8'h20);
      end else if (r < 80) begin
        ba = 4'($urandom_range(0, 15));
        if (ba == 4'h0 || ba == 4'h4 || ba == 4'h8) ba = 4'hC;
        apb(1'($urandom_range(0, 1)), ba, 8'($urandom));
      end else if (r < 88) begin
        inject_q.push_back(8'($urandom));
      end else begin
        apb(1'b0, 4'h8, 8'h00);
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    apb(1'b1, 4'h8, 8'h01);
    wait_quiet();
    drain();
    apb(1'b0, 4'h4, 8'h00);
    chk("tx_left", tx_model.size(), 0);
    chk("rx_left", rx_model.size(), 0);
    repeat (2) @(negedge clk);
    chk("apb_exp_left", apb_exp.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
